// File: rtl/i2c_master_seq.sv
// i2c_master_seq: byte-level I2C master sequencer (START, 8 data bits, ACK, STOP, arbitration).
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL by holding it low during q1/q2.
module i2c_master_seq #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       slow_clk,
  input  logic       i2c_rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_read,
  input  logic       cmd_ack,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       done,
  output logic       ack_rcvd,
  output logic       arb_lost,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       start,
  output logic       stop,
  output logic       busy
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       q_q, q_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;

  logic       stop_l, read_l, ack_l;
  logic [7:0] wr_l;
  logic       stop_n, read_n, ack_n;
  logic [7:0] wr_n;
  logic [7:0] shift_q, shift_d;
  logic       ack_smp_q, ack_smp_d;

  logic       cmd_ready_d, busy_d, scl_oe_d, sda_oe_d;
  logic       start_d, stop_d, done_d, ack_rcvd_d, arb_lost_d;
  logic [7:0] rd_data_d;

  logic accept, div_end, hold_div, qtr_end, phase_end, sample, arb;

  assign accept    = cmd_valid && cmd_ready;
  assign div_end   = (div_q == DIV_LAST);
  assign qtr_end   = div_end && !hold_div;
  assign phase_end = qtr_end && (q_q == 2'd3);
  assign sample    = ((state_q == S_DATA) || (state_q == S_ACK)) && (q_q == 2'd2) && qtr_end;
  // A released '1' that reads back low means another master won the bus
  assign arb       = (state_q == S_DATA) && !read_l && wr_l[bit_q] && sample && !sda_in;

`ifdef I2C_CLK_STRETCH_EN
  assign hold_div = ((q_q == 2'd1) || (q_q == 2'd2)) && !scl_oe && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign hold_div      = 1'b0;
`endif

  // Command fields as seen by the transfer being set up this cycle
  assign stop_n = accept ? cmd_stop  : stop_l;
  assign read_n = accept ? cmd_read  : read_l;
  assign ack_n  = accept ? cmd_ack   : ack_l;
  assign wr_n   = accept ? wr_data   : wr_l;

  // State, counters, command latch and registered outputs
  always_ff @(posedge slow_clk) begin
    if (i2c_rst) begin
      state_q   <= S_IDLE;
      q_q       <= 2'd0;
      div_q     <= '0;
      bit_q     <= 3'd0;
      stop_l    <= 1'b0;
      read_l    <= 1'b0;
      ack_l     <= 1'b0;
      wr_l      <= 8'h00;
      shift_q   <= 8'h00;
      ack_smp_q <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      start     <= 1'b0;
      stop      <= 1'b0;
      done      <= 1'b0;
      ack_rcvd  <= 1'b0;
      arb_lost  <= 1'b0;
      rd_data   <= 8'h00;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      stop_l    <= stop_n;
      read_l    <= read_n;
      ack_l     <= ack_n;
      wr_l      <= wr_n;
      shift_q   <= shift_d;
      ack_smp_q <= ack_smp_d;
      cmd_ready <= cmd_ready_d;
      busy      <= busy_d;
      scl_oe    <= scl_oe_d;
      sda_oe    <= sda_oe_d;
      start     <= start_d;
      stop      <= stop_d;
      done      <= done_d;
      ack_rcvd  <= ack_rcvd_d;
      arb_lost  <= arb_lost_d;
      rd_data   <= rd_data_d;
    end
  end

  // Next state and quarter/divider/bit counters
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    div_d   = div_q;
    bit_d   = bit_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (accept) begin
          state_d = ((state_q == S_IDLE) || cmd_start) ? S_START : S_DATA;
          q_d     = 2'd0;
          div_d   = '0;
          bit_d   = 3'd7;
        end
      end
      default: begin
        if (qtr_end) begin
          div_d = '0;
          q_d   = q_q + 2'd1;
        end else if (!hold_div) begin
          div_d = div_q + DIV_W'(1);
        end
        if (phase_end) begin
          case (state_q)
            S_START: state_d = S_DATA;
            S_DATA: begin
              if (bit_q == 3'd0) state_d = S_ACK;
              else               bit_d   = bit_q - 3'd1;
            end
            S_ACK:   state_d = stop_l ? S_STOP : S_HOLD;
            S_STOP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
          endcase
        end
        if (arb) begin
          state_d = S_IDLE;
          q_d     = 2'd0;
          div_d   = '0;
        end
      end
    endcase
  end

  // Next values of bus drives, status pulses and receive datapath
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_HOLD);
    busy_d      = (state_d != S_IDLE);
    scl_oe_d    = 1'b0;
    sda_oe_d    = 1'b0;
    // start marks the final START cycle, while SCL is being pulled low
    start_d     = (state_d == S_START) && (q_d == 2'd3) && (div_d == DIV_LAST);
    stop_d      = (state_q == S_STOP) && phase_end;
    done_d      = (state_q == S_ACK) && phase_end;
    ack_rcvd_d  = done_d && !read_l && !ack_smp_q;
    arb_lost_d  = arb;
    rd_data_d   = (done_d && read_l) ? shift_q : rd_data;
    shift_d     = (sample && (state_q == S_DATA)) ? {shift_q[6:0], sda_in} : shift_q;
    ack_smp_d   = (sample && (state_q == S_ACK)) ? sda_in : ack_smp_q;
    case (state_d)
      S_START: begin
        case (q_d)
          2'd0:    scl_oe_d = scl_oe;
          2'd1:    scl_oe_d = 1'b0;
          2'd2:    sda_oe_d = 1'b1;
          default: begin
            scl_oe_d = 1'b1;
            sda_oe_d = 1'b1;
          end
        endcase
      end
      S_DATA, S_ACK: begin
        scl_oe_d = (q_d == 2'd0) || (q_d == 2'd3);
        if (state_d == S_DATA) sda_oe_d = !read_n && !wr_n[bit_d];
        else                   sda_oe_d = read_n && !ack_n;
      end
      S_STOP: begin
        scl_oe_d = (q_d == 2'd0);
        sda_oe_d = (q_d == 2'd0) || (q_d == 2'd1);
      end
      S_HOLD:  scl_oe_d = 1'b1;
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase
  end

endmodule
